// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell (two half adders plus an OR)
// processes one operand bit per clock, LSB first, under a start/busy/done handshake.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             c;
   logic [CNT_W-1:0] cnt;
   logic             last_bit;
   logic             ha1_s;
   logic             ha1_c;
   logic             ha2_c;
   logic             fa_s;
   logic             fa_c;

   always_comb begin
      ha1_s = a_sh[0] ^ b_sh[0];
      ha1_c = a_sh[0] & b_sh[0];
      fa_s  = ha1_s ^ c;
      ha2_c = ha1_s & c;
      fa_c  = ha1_c | ha2_c;
   end

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ADD;
         ADD:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done are decoded from the next state so they come straight off flops
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == ADD);
         done  <= (state_nxt == DONE);
      end
   end

   // Operand A's register doubles as the sum shift register: each sum bit enters
   // at the MSB as the consumed operand bit leaves at the LSB.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_sh      <= '0;
         b_sh      <= '0;
         c         <= 1'b0;
         cnt       <= '0;
         sum_out   <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a_in;
                  b_sh <= b_in;
                  c    <= 1'b0;
                  cnt  <= '0;
               end
            end
            ADD: begin
               a_sh <= {fa_s, a_sh[WIDTH-1:1]};
               b_sh <= {1'b0, b_sh[WIDTH-1:1]};
               c    <= fa_c;
               cnt  <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sum_out   <= {fa_s, a_sh[WIDTH-1:1]};
                  carry_out <= fa_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboarded bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_adder_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
   logic        busy8, done8, carry8;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, sum16;
   logic        busy16, done16, carry16;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
      .busy(busy8), .done(done8), .sum_out(sum8), .carry_out(carry8)
   );

   serial_adder_ctrl #(.WIDTH(16)) dut16 (
      .clock(clock), .reset(reset), .start(start16), .a_in(a16), .b_in(b16),
      .busy(busy16), .done(done16), .sum_out(sum16), .carry_out(carry16)
   );

   int errors = 0;
   int checks = 0;

   logic [8:0]  q8[$];
   logic [16:0] q16[$];
   logic [8:0]  held8 = '0;
   logic [16:0] held16 = '0;
   logic [8:0]  exp8;
   logic [16:0] exp16;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the result is plain (WIDTH+1)-bit addition
   always @(posedge reset) begin
      held8  = '0;
      held16 = '0;
   end

   always @(negedge clock) begin
      if (!reset) begin
         chk("overlap8", 32'(busy8 & done8), 32'd0);
         if (done8) begin
            checks++;
            if (q8.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done8: got sum %0h with no request pending", sum8);
            end else begin
               exp8 = q8.pop_front();
               chk("result8", 32'({carry8, sum8}), 32'(exp8));
               held8 = exp8;
            end
         end else begin
            chk("hold8", 32'({carry8, sum8}), 32'(held8));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         chk("overlap16", 32'(busy16 & done16), 32'd0);
         if (done16) begin
            checks++;
            if (q16.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done16: got sum %0h with no request pending", sum16);
            end else begin
               exp16 = q16.pop_front();
               chk("result16", 32'({carry16, sum16}), 32'(exp16));
               held16 = exp16;
            end
         end else begin
            chk("hold16", 32'({carry16, sum16}), 32'(held16));
         end
      end
   end

   // Drives a request while the DUT is idle; returns at the first negedge after acceptance
   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      @(negedge clock);
      start8 = 1'b1;
      a8 = a;
      b8 = b;
      q8.push_back({1'b0, a} + {1'b0, b});
      @(negedge clock);
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
   endtask

   // n0 = how many negedges have passed since the accepting edge
   task automatic wait_done8(input int n0, input bit count_busy);
      int n;
      int bc;
      n = n0;
      bc = 0;
      while (!done8 && n < 40) begin
         if (busy8) bc++;
         @(negedge clock);
         n++;
      end
      chk("done8_seen", 32'(done8), 32'd1);
      chk("latency8", 32'(n), 32'd9);
      if (count_busy) chk("busy_cycles8", 32'(bc), 32'd8);
   endtask

   initial begin : main
      int n;
      int first;
      int second;

      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_sum", 32'(sum8), 32'd0);
      chk("rst_carry", 32'(carry8), 32'd0);
      @(posedge clock);
      #2 reset = 1'b0;

      issue8(8'h0F, 8'h01); wait_done8(1, 1'b1);
      issue8(8'hFF, 8'h01); wait_done8(1, 1'b1);
      issue8(8'hFF, 8'hFF); wait_done8(1, 1'b1);
      issue8(8'h00, 8'h00); wait_done8(1, 1'b1);

      // A request arriving mid-operation is dropped
      issue8(8'h12, 8'h34);
      repeat (2) @(negedge clock);
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      @(negedge clock);
      start8 = 1'b0;
      wait_done8(4, 1'b0);
      repeat (15) @(negedge clock);
      chk("no_queue_after_ignore", 32'(q8.size()), 32'd0);

      // Asynchronous reset in the middle of an add
      issue8(8'h80, 8'h80);
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy8), 32'd0);
      chk("arst_done", 32'(done8), 32'd0);
      chk("arst_sum", 32'(sum8), 32'd0);
      chk("arst_carry", 32'(carry8), 32'd0);
      q8.delete();
      @(posedge clock);
      #2 reset = 1'b0;
      repeat (15) @(negedge clock);
      issue8(8'h80, 8'h80); wait_done8(1, 1'b1);

      // Start held high: two back-to-back operations
      @(negedge clock);
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
      q8.push_back(9'h003);
      @(negedge clock);
      a8 = 8'h03; b8 = 8'h04;
      q8.push_back(9'h007);
      n = 1; first = -1; second = -1;
      while (second < 0 && n < 60) begin
         if (done8) begin
            if (first < 0) first = n;
            else second = n;
         end
         if (n == 15) chk("b2b_hold_sum", 32'(sum8), 32'h03);
         if (second < 0) begin
            @(negedge clock);
            n++;
         end
      end
      start8 = 1'b0;
      chk("b2b_first_latency", 32'(first), 32'd9);
      chk("b2b_spacing", 32'(second - first), 32'd10);

      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clock);
         issue8(8'($urandom), 8'($urandom));
         wait_done8(1, 1'b1);
      end

      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clock);
         @(negedge clock);
         start16 = 1'b1;
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         if (i == 0) begin a16 = 16'hFFFF; b16 = 16'h0001; end
         q16.push_back({1'b0, a16} + {1'b0, b16});
         @(negedge clock);
         start16 = 1'b0;
         a16 = 16'($urandom);
         n = 1;
         while (!done16 && n < 60) begin
            @(negedge clock);
            n++;
         end
         chk("done16_seen", 32'(done16), 32'd1);
         chk("latency16", 32'(n), 32'd17);
      end

      repeat (4) @(negedge clock);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("q16_drained", 32'(q16.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-shares a single full-adder cell, built from two half-adder stages plus an OR on the carries, across all bits of two WIDTH-bit operands, one bit per clock. A start/busy/done handshake sequences it, and it latches the result and final carry for the requester. It sits between a requesting block and the shared 1-bit add datapath and owns operand shifting, carry storage and bit counting.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clock      input   1      rising-edge system clock
reset      input   1      asynchronous, active-high reset
start      input   1      request pulse; sampled only in IDLE
a_in       input   WIDTH  operand A; captured on the accepted start edge
b_in       input   WIDTH  operand B; captured on the accepted start edge
busy       output  1      high while in ADD
done       output  1      one-cycle pulse; result valid
sum_out    output  WIDTH  A+B modulo 2^WIDTH; held until next completion
carry_out  output  1      carry out of bit WIDTH-1; held with sum_out

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, sum_out=0, carry_out=0.
  - Internal operand, sum shift registers, carry flop and bit counter all cleared.
  - In-flight operation discarded; no done pulse is generated for it.
- States: IDLE, ADD, DONE. All transitions on the rising clock edge.
- IDLE:
  - start=1 at edge E0: load a_in/b_in into shift registers, carry flop=0, counter=0, go to ADD.
  - start=0: stay in IDLE.
- ADD, each edge:
  - s = a[0]^b[0]^c; c_next = (a[0]&b[0]) | (c&(a[0]^b[0])).
  - Shift s into the MSB of the sum shift register; shift A and B right by one; counter++.
  - At the edge where counter==WIDTH-1 (edge E_WIDTH): load sum_out from the final shifted value and carry_out=c_next, go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: start accepted at E0 -> done high during the cycle following edge E_WIDTH (WIDTH cycles after E0). Throughput is one operation per WIDTH+2 cycles.
- busy=1 exactly in ADD (WIDTH cycles). done and busy are never high together.
- start while in ADD or DONE: ignored, no queuing. a_in/b_in changes during ADD have no effect.
- sum_out/carry_out change only at the transition into DONE (or on reset). They are stable otherwise, including through IDLE and the next ADD.
- Overflow wraps modulo 2^WIDTH; carry_out reports it.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8; reset, then start with a_in=8'h0F, b_in=8'h01 -> busy high for 8 cycles; done pulses 1 cycle 8 cycles after accept; sum_out=8'h10, carry_out=0.
- a_in=8'hFF, b_in=8'h01 -> sum_out=8'h00, carry_out=1 (full ripple). Then a_in=8'hFF, b_in=8'hFF -> sum_out=8'hFE, carry_out=1. Then 8'h00+8'h00 -> 8'h00, carry_out=0.
- Start 8'h12+8'h34; pulse start with 8'hAA/8'h55 on cycle 3 of ADD -> second request ignored; result 8'h46, carry_out 0; exactly one done pulse.
- Start 8'h80+8'h80 and assert reset on ADD cycle 4 -> busy, done, sum_out, carry_out all 0 immediately (asynchronously); no done pulse follows. Next start 8'h80+8'h80 -> 8'h00, carry_out=1.
- Back-to-back: hold start high continuously with 8'h01+8'h02, then 8'h03+8'h04 -> accepts spaced WIDTH+2 cycles apart; results 8'h03 then 8'h07; sum_out holds 8'h03 until the second done.
- Random regression: 200 random operand pairs at WIDTH=8 and WIDTH=16 compared against {carry,sum}=a+b; busy/done never simultaneously high.
